// File: rtl/barrett_pkg.sv
// Types and constants for the Barrett parameter generator.
package barrett_pkg;

  import multiplier_pkg::*;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DIVIDE,
    DONE
  } param_state_t;

  // Largest accepted modulus bitlength; keeps mu = floor(2^(2k)/m) inside DATA_LENGTH bits.
  localparam int unsigned MAX_BL = DATA_LENGTH - 2;

endpackage : barrett_pkg

// File: rtl/multiplier_pkg.sv
// Shared operand width for the Barrett multiplier / reduction datapath.
package multiplier_pkg;

  localparam int unsigned DATA_LENGTH = 64;

endpackage : multiplier_pkg

// File: rtl/barrett_mu_divider.sv
// Bit-serial restoring divider computing floor(2^(2k) / divisor).
// start_i loads the quotient bit count (2k+1); one quotient bit is produced
// per cycle after that, and done_o marks the cycle of the final bit with
// quotient_o already carrying the finished quotient.
module barrett_mu_divider #(
  parameter int unsigned DATA_LENGTH = multiplier_pkg::DATA_LENGTH,
  parameter int unsigned CNT_W       = $clog2(DATA_LENGTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] divisor_i,
  input  logic [CNT_W-1:0]       count_i,
  output logic [DATA_LENGTH-1:0] quotient_o,
  output logic                   done_o
);

  logic [DATA_LENGTH-1:0] rem_q, rem_d;
  logic [DATA_LENGTH-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   first_q, first_d;
  logic [DATA_LENGTH-1:0] rem_shift;

  // One restoring-division step per cycle; the dividend is a single 1 followed by zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    // rem < divisor < 2^(DATA_LENGTH-2), so the top bit dropped by the shift is always 0.
    rem_shift = {rem_q[DATA_LENGTH-2:0], first_q};

    if (start_i) begin
      rem_d   = '0;
      quo_d   = '0;
      cnt_d   = count_i;
      first_d = 1'b1;
    end else if (cnt_q != '0) begin
      if (rem_shift >= divisor_i) begin
        rem_d = rem_shift - divisor_i;
        quo_d = {quo_q[DATA_LENGTH-2:0], 1'b1};
      end else begin
        rem_d = rem_shift;
        quo_d = {quo_q[DATA_LENGTH-2:0], 1'b0};
      end
      cnt_d   = cnt_q - CNT_W'(1);
      first_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign done_o     = (cnt_q == CNT_W'(1));
  assign quotient_o = quo_d;

endmodule : barrett_mu_divider

// File: rtl/barrett_param_gen.sv
// Barrett parameter generator: from a modulus m derive its bitlength k and
// the reciprocal mu = floor(2^(2k)/m). A bit scan finds k, then the serial
// divider produces mu; results are presented with a one-cycle valid pulse.
module barrett_param_gen
  import barrett_pkg::*;
#(
  parameter int unsigned DATA_LENGTH = multiplier_pkg::DATA_LENGTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  output logic                   ready_o,
  output logic                   valid_o,
  output logic                   err_o,
  output logic [DATA_LENGTH-1:0] m_o,
  output logic [DATA_LENGTH-1:0] m_bl_o,
  output logic [DATA_LENGTH-1:0] mu_o
);

  localparam int unsigned BL_W = $clog2(DATA_LENGTH);
  localparam int unsigned CNT_W = BL_W + 1;
  localparam logic [BL_W-1:0] SCAN_TOP = BL_W'(DATA_LENGTH - 3);

  param_state_t state_q, state_d;

  logic [DATA_LENGTH-1:0] m_work_q, m_work_d;
  logic [BL_W-1:0]        scan_idx_q, scan_idx_d;
  logic [BL_W-1:0]        k_q, k_d;
  logic [DATA_LENGTH-1:0] m_out_q, m_out_d;
  logic [DATA_LENGTH-1:0] m_bl_q, m_bl_d;
  logic [DATA_LENGTH-1:0] mu_q, mu_d;
  logic                   err_q, err_d;
  logic                   valid_q, valid_d;

  logic                   m_bad;
  logic                   scan_hit;
  logic [BL_W-1:0]        k_found;
  logic                   div_start;
  logic                   div_done;
  logic [DATA_LENGTH-1:0] div_quotient;

  assign m_bad    = (m_i == '0) || (m_i[DATA_LENGTH-1:DATA_LENGTH-2] != 2'b00);
  assign scan_hit = m_work_q[scan_idx_q];
  assign k_found  = scan_idx_q + BL_W'(1);

  barrett_mu_divider #(
    .DATA_LENGTH (DATA_LENGTH),
    .CNT_W       (CNT_W)
  ) u_divider (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .divisor_i  (m_work_q),
    .count_i    ({k_found, 1'b1}),
    .quotient_o (div_quotient),
    .done_o     (div_done)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)  state_d = m_bad ? DONE : SCAN;
      SCAN:    if (scan_hit) state_d = DIVIDE;
      DIVIDE:  if (div_done) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath and output-register updates per state.
  always_comb begin
    m_work_d   = m_work_q;
    scan_idx_d = scan_idx_q;
    k_d        = k_q;
    m_out_d    = m_out_q;
    m_bl_d     = m_bl_q;
    mu_d       = mu_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    div_start  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_work_d   = m_i;
          scan_idx_d = SCAN_TOP;
          err_d      = m_bad;
          if (m_bad) begin
            // Rejected modulus: publish immediately with zeroed parameters.
            m_out_d = m_i;
            m_bl_d  = '0;
            mu_d    = '0;
            valid_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (scan_hit) begin
          k_d       = k_found;
          div_start = 1'b1;
        end else begin
          scan_idx_d = scan_idx_q - BL_W'(1);
        end
      end
      DIVIDE: begin
        if (div_done) begin
          m_out_d = m_work_q;
          m_bl_d  = DATA_LENGTH'(k_q);
          mu_d    = div_quotient;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Working and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_work_q   <= '0;
      scan_idx_q <= '0;
      k_q        <= '0;
      m_out_q    <= '0;
      m_bl_q     <= '0;
      mu_q       <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      m_work_q   <= m_work_d;
      scan_idx_q <= scan_idx_d;
      k_q        <= k_d;
      m_out_q    <= m_out_d;
      m_bl_q     <= m_bl_d;
      mu_q       <= mu_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = valid_q;
  assign err_o   = err_q;
  assign m_o     = m_out_q;
  assign m_bl_o  = m_bl_q;
  assign mu_o    = mu_q;

endmodule : barrett_param_gen
